// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage
// Cracks a fetched RV32I instruction into ALU/branch controls, register
// addresses, class flags and sign-extended immediates. The decoded bundle is
// registered in MAIN and backed by a one-entry SKID register, so the stage
// runs at full throughput while in_ready stays a plain flop output.
module rv32i_decode_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [WIDTH-1:0] in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pc,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   output logic [4:0]       rd_addr,
   output logic             rd_we,
   output logic [2:0]       funct3,
   output logic [6:0]       funct7,
   output logic             isALUreg,
   output logic             isALUimm,
   output logic             isBranch,
   output logic             isLoad,
   output logic             isStore,
   output logic             isJAL,
   output logic             isJALR,
   output logic             isLUI,
   output logic             isAUIPC,
   output logic             isSYSTEM,
   output logic             isFENCE,
   output logic [WIDTH-1:0] Iimm,
   output logic [WIDTH-1:0] Simm,
   output logic [WIDTH-1:0] Bimm,
   output logic [WIDTH-1:0] Uimm,
   output logic [WIDTH-1:0] Jimm,
   output logic             illegal
);

   // Bit positions of the instruction class flags inside the stored bundle.
   localparam int C_ALUREG = 10;
   localparam int C_ALUIMM = 9;
   localparam int C_BRANCH = 8;
   localparam int C_LOAD   = 7;
   localparam int C_STORE  = 6;
   localparam int C_JAL    = 5;
   localparam int C_JALR   = 4;
   localparam int C_LUI    = 3;
   localparam int C_AUIPC  = 2;
   localparam int C_SYSTEM = 1;
   localparam int C_FENCE  = 0;

   // Classes that write a destination register.
   localparam logic [10:0] WRITERS = 11'h6BC;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic             rdWe;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [10:0]      cls;
      logic [WIDTH-1:0] iImm;
      logic [WIDTH-1:0] sImm;
      logic [WIDTH-1:0] bImm;
      logic [WIDTH-1:0] uImm;
      logic [WIDTH-1:0] jImm;
      logic             illegal;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   entry_t     main_q, main_d;
   entry_t     skid_q, skid_d;
   logic       inReady_q, inReady_d;
   entry_t     decoded;
   logic       badEnc;
   logic       accept;
   logic       consume;
   logic [6:0] opcode;

   assign opcode  = in_instr[6:0];
   assign accept  = in_valid & inReady_q;
   assign consume = (state_q != EMPTY) & out_ready;

   // Combinational decode of the incoming word into a storable bundle.
   always_comb begin
      decoded        = '0;
      badEnc         = 1'b0;
      decoded.pc     = in_pc;
      decoded.rs1    = in_instr[19:15];
      decoded.rs2    = in_instr[24:20];
      decoded.rd     = in_instr[11:7];
      decoded.funct3 = in_instr[14:12];
      decoded.funct7 = in_instr[31:25];
      decoded.iImm   = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
      decoded.sImm   = {{(WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      decoded.bImm   = {{(WIDTH-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      decoded.uImm   = {{(WIDTH-32){in_instr[31]}}, in_instr[31:12], 12'b0};
      decoded.jImm   = {{(WIDTH-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      case (opcode)
         7'b0110011: begin
            decoded.cls[C_ALUREG] = 1'b1;
            if (!((decoded.funct7 == 7'h00) ||
                  ((decoded.funct7 == 7'h20) && (decoded.funct3 inside {3'b000, 3'b101}))))
               badEnc = 1'b1;
         end
         7'b0010011: begin
            decoded.cls[C_ALUIMM] = 1'b1;
            if ((decoded.funct3 == 3'b001) && (decoded.funct7 != 7'h00))
               badEnc = 1'b1;
            if ((decoded.funct3 == 3'b101) && !(decoded.funct7 inside {7'h00, 7'h20}))
               badEnc = 1'b1;
         end
         7'b1100011: begin
            decoded.cls[C_BRANCH] = 1'b1;
            if (decoded.funct3 inside {3'b010, 3'b011}) badEnc = 1'b1;
         end
         7'b0000011: begin
            decoded.cls[C_LOAD] = 1'b1;
            if (decoded.funct3 inside {3'b011, 3'b110, 3'b111}) badEnc = 1'b1;
         end
         7'b0100011: begin
            decoded.cls[C_STORE] = 1'b1;
            if (decoded.funct3 > 3'b010) badEnc = 1'b1;
         end
         7'b1101111: decoded.cls[C_JAL] = 1'b1;
         7'b1100111: begin
            decoded.cls[C_JALR] = 1'b1;
            if (decoded.funct3 != 3'b000) badEnc = 1'b1;
         end
         7'b0110111: decoded.cls[C_LUI]    = 1'b1;
         7'b0010111: decoded.cls[C_AUIPC]  = 1'b1;
         7'b1110011: decoded.cls[C_SYSTEM] = 1'b1;
         7'b0001111: decoded.cls[C_FENCE]  = 1'b1;
         default:    badEnc = 1'b1;
      endcase
      if (in_instr[1:0] != 2'b11) badEnc = 1'b1;
      if (badEnc) decoded.cls = '0;
      decoded.illegal = badEnc;
      decoded.rdWe    = (|(decoded.cls & WRITERS)) && (decoded.rd != 5'd0);
   end

   // Handshake FSM: decides where an accepted entry lands and what MAIN shows next.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         skid_d  = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = decoded;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (accept && consume) begin
                  main_d = decoded;
               end else if (consume) begin
                  state_d = EMPTY;
               end else if (accept) begin
                  skid_d  = decoded;
                  state_d = FULL;
               end
            end
            FULL: begin
               if (consume) begin
                  main_d  = skid_q;
                  state_d = BUSY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      inReady_d = (state_d != FULL);
   end

   // State, buffers and the registered ready flag; reset empties the stage at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         inReady_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         inReady_q <= inReady_d;
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = (state_q != EMPTY);
   assign out_pc    = main_q.pc;
   assign rs1_addr  = main_q.rs1;
   assign rs2_addr  = main_q.rs2;
   assign rd_addr   = main_q.rd;
   assign rd_we     = main_q.rdWe;
   assign funct3    = main_q.funct3;
   assign funct7    = main_q.funct7;
   assign isALUreg  = main_q.cls[C_ALUREG];
   assign isALUimm  = main_q.cls[C_ALUIMM];
   assign isBranch  = main_q.cls[C_BRANCH];
   assign isLoad    = main_q.cls[C_LOAD];
   assign isStore   = main_q.cls[C_STORE];
   assign isJAL     = main_q.cls[C_JAL];
   assign isJALR    = main_q.cls[C_JALR];
   assign isLUI     = main_q.cls[C_LUI];
   assign isAUIPC   = main_q.cls[C_AUIPC];
   assign isSYSTEM  = main_q.cls[C_SYSTEM];
   assign isFENCE   = main_q.cls[C_FENCE];
   assign Iimm      = main_q.iImm;
   assign Simm      = main_q.sImm;
   assign Bimm      = main_q.bImm;
   assign Uimm      = main_q.uImm;
   assign Jimm      = main_q.jImm;
   assign illegal   = main_q.illegal;

endmodule
